// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 keyboard receive path.
package ps2_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;
endpackage

// File: rtl/ps2_fifo.sv
// First-word-fall-through FIFO; a pop on the full cycle frees room for a same-cycle push.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // Push-while-empty never needs the pop; push-while-full relies on it.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: pin synchronizer, clock glitch filter, frame
// deframer with timeout, sticky error flags and a pop-on-read scancode FIFO.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       valid,
  output logic       irq,
  output logic       overflow,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 2);

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] flt_cnt;
  logic          flt_clk;
  logic          fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt <= '0;
      flt_clk <= 1'b1;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_clk <= clk_s2;
        flt_cnt <= '0;
        fall    <= ~clk_s2;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  ps2_state_e               state, state_n;
  logic [3:0]               bit_cnt, bit_cnt_n;
  logic [PS2_DATA_BITS:0]   shreg, shreg_n;
  logic [TW-1:0]            to_cnt, to_cnt_n;
  logic                     push_req, perr_ev, ferr_ev;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    to_cnt_n  = to_cnt;
    push_req  = 1'b0;
    perr_ev   = 1'b0;
    ferr_ev   = 1'b0;
    case (state)
      IDLE: begin
        to_cnt_n = '0;
        if (fall && !dat_s2) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          to_cnt_n = '0;
          if (bit_cnt == LAST_BIT) begin
            // shreg holds data+parity; dat_s2 is the stop bit.
            state_n  = IDLE;
            perr_ev  = ~(^shreg);
            ferr_ev  = ~dat_s2;
            push_req = (^shreg) & dat_s2;
          end else begin
            shreg_n   = {dat_s2, shreg[PS2_DATA_BITS:1]};
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          ferr_ev = 1'b1;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic                     push_q;
  logic [PS2_DATA_BITS-1:0] push_data_q;
  logic                     fifo_full, fifo_empty, fifo_pop, ovf_ev;
  logic [CW-1:0]            fifo_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      to_cnt      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      to_cnt      <= to_cnt_n;
      push_q      <= push_req;
      if (push_req) push_data_q <= shreg[PS2_DATA_BITS-1:0];
      // A set in the same cycle as clr_err wins.
      overflow    <= ovf_ev  | (overflow   & ~clr_err);
      frame_err   <= ferr_ev | (frame_err  & ~clr_err);
      parity_err  <= perr_ev | (parity_err & ~clr_err);
    end
  end

  assign fifo_pop = rd & ~fifo_empty;
  assign ovf_ev   = push_q & fifo_full & ~fifo_pop;

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (fifo_pop),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign valid = (fifo_count != '0);
  assign irq   = valid;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frame driver, queue-based reference model
// checked every cycle while outputs are settled, plus literal timing/data checks.
module tb_ps2_keyboard_rx;
  localparam int DEPTH = 8;
  localparam int FLT   = 8;
  localparam int TO    = 300;
  localparam int HALF  = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       valid, irq, overflow, frame_err, parity_err;

  ps2_keyboard_rx #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd         (rd),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .valid      (valid),
    .irq        (irq),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // clock
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovf = 0, exp_perr = 0, exp_ferr = 0;
  bit         chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // Reference model: effect of one complete frame on FIFO contents and flags.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop,
                             input bit popped);
    bit par_ok;
    par_ok = ((^{par, d}) == 1'b1);
    if (!par_ok) exp_perr = 1;
    if (!stop)   exp_ferr = 1;
    if (popped && exp_q.size() != 0) void'(exp_q.pop_front());
    if (par_ok && stop) begin
      if (exp_q.size() >= DEPTH) exp_ovf = 1;
      else exp_q.push_back(d);
    end
  endtask

  // scoreboard compare
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {31'd0, valid}, {31'd0, exp_q.size() != 0});
      check("irq", {31'd0, irq}, {31'd0, exp_q.size() != 0});
      check("rd_data", {24'd0, rd_data}, {24'd0, (exp_q.size() != 0) ? exp_q[0] : 8'h00});
      check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      check("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
      check("parity_err", {31'd0, parity_err}, {31'd0, exp_perr});
    end
  end

  // Drives nbits of {stop, par, d, start}; on the last bit measures cycles from
  // the raw falling edge to valid / any error flag, and optionally pulses rd
  // on the cycle the frame is written into the FIFO.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit rd_sync,
                            output int lat_v, output int lat_e, output logic [7:0] rd_got);
    logic [10:0] bits;
    bits   = {stop, par, d, 1'b0};
    lat_v  = -1;
    lat_e  = -1;
    rd_got = 8'h00;
    chk_en = 0;
    for (int b = 0; b < nbits; b++) begin
      ps2_data = bits[b];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      for (int i = 1; i <= HALF; i++) begin
        @(posedge clk); #1;
        if (b == nbits - 1) begin
          if (lat_v < 0 && valid) lat_v = i;
          if (lat_e < 0 && (parity_err || frame_err)) lat_e = i;
          if (rd_sync && i == FLT + 3) begin
            rd_got = rd_data;
            rd = 1'b1;
          end
          if (rd_sync && i == FLT + 4) rd = 1'b0;
        end
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic good_frame(input logic [7:0] d);
    int lv, le;
    logic [7:0] g;
    send_frame(d, odd_par(d), 1'b1, 11, 1'b0, lv, le, g);
    model_frame(d, odd_par(d), 1'b1, 1'b0);
    chk_en = 1;
  endtask

  task automatic do_read(output logic [7:0] got);
    @(posedge clk); #1;
    rd  = 1'b1;
    got = rd_data;
    @(posedge clk); #1;
    rd = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic do_clr;
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    exp_ovf = 0; exp_perr = 0; exp_ferr = 0;
  endtask

  task automatic do_reset;
    chk_en = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_ovf = 0; exp_perr = 0; exp_ferr = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lv, le;
    logic [7:0] g;

    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_rd_data", {24'd0, rd_data}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_flags", {29'd0, overflow, frame_err, parity_err}, 32'd0);
    chk_en = 1;

    // rd on empty FIFO is ignored
    do_read(g);
    check("empty_read_data", {24'd0, g}, 32'h00);

    // basic good frame with latency
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, lv, le, g);
    check("lat_valid_1c", lv, FLT + 4);
    check("no_err_1c", le, -1);
    check("rd_data_1c", {24'd0, rd_data}, 32'h1C);
    model_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk_en = 1;
    do_read(g);
    check("read_1c", {24'd0, g}, 32'h1C);
    @(negedge clk);
    check("after_read_valid", {31'd0, valid}, 32'd0);
    check("after_read_data", {24'd0, rd_data}, 32'h00);

    // parity error
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0, lv, le, g);
    check("lat_perr_f0", le, FLT + 3);
    check("perr_f0", {31'd0, parity_err}, 32'd1);
    check("valid_f0", {31'd0, valid}, 32'd0);
    model_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    chk_en = 1;
    do_clr();
    @(negedge clk);
    check("perr_cleared", {31'd0, parity_err}, 32'd0);

    // bad stop bit and both-bad
    send_frame(8'h3C, odd_par(8'h3C), 1'b0, 11, 1'b0, lv, le, g);
    model_frame(8'h3C, odd_par(8'h3C), 1'b0, 1'b0);
    chk_en = 1;
    check("ferr_stop", {31'd0, frame_err}, 32'd1);
    send_frame(8'h3C, ~odd_par(8'h3C), 1'b0, 11, 1'b0, lv, le, g);
    model_frame(8'h3C, ~odd_par(8'h3C), 1'b0, 1'b0);
    chk_en = 1;
    check("both_err", {30'd0, frame_err, parity_err}, 32'd3);
    do_clr();

    // timeout after start + 4 bits
    send_frame(8'h5A, 1'b1, 1'b1, 5, 1'b0, lv, le, g);
    repeat (TO / 2) @(posedge clk);
    #1 check("no_early_timeout", {31'd0, frame_err}, 32'd0);
    repeat (TO) @(posedge clk);
    #1 check("timeout_ferr", {31'd0, frame_err}, 32'd1);
    exp_ferr = 1;
    chk_en = 1;
    do_clr();
    good_frame(8'h5A);
    do_read(g);
    check("read_5a", {24'd0, g}, 32'h5A);

    // overflow
    for (int v = 1; v <= 9; v++) good_frame(8'(v));
    check("overflow_set", {31'd0, overflow}, 32'd1);
    for (int v = 1; v <= 8; v++) begin
      do_read(g);
      check("ovf_drain", {24'd0, g}, v);
    end
    @(negedge clk);
    check("ovf_empty", {31'd0, valid}, 32'd0);
    do_clr();

    // full FIFO, push coinciding with pop
    for (int v = 1; v <= 8; v++) good_frame(8'(v));
    send_frame(8'h0A, odd_par(8'h0A), 1'b1, 11, 1'b1, lv, le, g);
    check("sim_pop_data", {24'd0, g}, 32'h01);
    model_frame(8'h0A, odd_par(8'h0A), 1'b1, 1'b1);
    chk_en = 1;
    check("sim_no_ovf", {31'd0, overflow}, 32'd0);
    for (int v = 2; v <= 9; v++) begin
      do_read(g);
      check("sim_drain", {24'd0, g}, (v == 9) ? 32'h0A : v);
    end
    @(negedge clk);
    check("sim_empty", {31'd0, valid}, 32'd0);

    // short glitch on ps2_clk while idle
    @(posedge clk); #1;
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (FLT - 1) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1 ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    good_frame(8'h1C);
    do_read(g);
    check("post_glitch_1c", {24'd0, g}, 32'h1C);
    check("post_glitch_flags", {29'd0, overflow, frame_err, parity_err}, 32'd0);

    // reset mid-frame with a byte already queued
    good_frame(8'h33);
    send_frame(8'h77, 1'b0, 1'b1, 5, 1'b0, lv, le, g);
    do_reset();
    check("rst_valid", {31'd0, valid}, 32'd0);
    good_frame(8'h29);
    check("rst_head_29", {24'd0, rd_data}, 32'h29);
    do_read(g);
    check("read_29", {24'd0, g}, 32'h29);
    @(negedge clk);
    check("rst_final_valid", {31'd0, valid}, 32'd0);
    check("rst_final_flags", {29'd0, overflow, frame_err, parity_err}, 32'd0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
